// File: rtl/seg_display_arbiter_if.sv
// Bundles the requester side and seg7 side of the display arbiter.
// The master drives requests and the dwell select; the slave is the arbiter.
interface seg_display_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [4*NUM_REQ-1:0] req_digit;
  logic [7:0]           dwell_sel;
  logic [NUM_REQ-1:0]   grant;
  logic [3:0]           seg_digit;
  logic                 seg_blank;
  logic                 dwell_tick;

  modport master (
    output req, req_digit, dwell_sel,
    input  grant, seg_digit, seg_blank, dwell_tick
  );

  modport slave (
    input  req, req_digit, dwell_sel,
    output grant, seg_digit, seg_blank, dwell_tick
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the single seg7 digit path with a minimum dwell per grant.
// Define SEG_ARB_PREEMPT_EN to make requester 0 high priority (preempts other owners).
module seg_display_arbiter #(
  parameter int unsigned        NUM_REQ       = 4,
  parameter int unsigned        DWELL_W       = 24,
  parameter logic [DWELL_W-1:0] DEFAULT_DWELL = DWELL_W'(24'd10_000_000)
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   ena,
  seg_display_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e               state_q, state_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [3:0]           digit_q, digit_d;
  logic                 blank_q, blank_d;
  logic                 tick_q, tick_d;

  logic [DWELL_W-1:0]   cmp;
  logic [PTR_W-1:0]     cand;
  logic [PTR_W-1:0]     win_idx;
  logic                 win_found;
  logic                 expire;
  logic                 owner_req;
  logic                 others_req;
  logic                 preempt;

  always_comb begin
    cmp = (bus.dwell_sel == 8'd0) ? DEFAULT_DWELL : DWELL_W'({bus.dwell_sel, 10'b0});
  end

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`ifdef SEG_ARB_PREEMPT_EN
    if (bus.req[0]) begin
      win_found = 1'b1;
      win_idx   = '0;
    end
`endif
  end

  assign expire     = (cnt_q == cmp);
  assign owner_req  = bus.req[ptr_q];
  assign others_req = |(bus.req & ~grant_q);

`ifdef SEG_ARB_PREEMPT_EN
  assign preempt = bus.req[0] && (ptr_q != '0);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    digit_d = digit_q;
    blank_d = blank_q;
    tick_d  = 1'b0;
    if (ena) begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_d          = StShow;
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            digit_d          = bus.req_digit[{win_idx, 2'b00} +: 4];
            blank_d          = 1'b0;
            cnt_d            = '0;
            ptr_d            = win_idx;
          end
        end
        StShow: begin
          cnt_d = cnt_q + 1'b1;
          if (preempt) begin
            state_d = StIdle;
            grant_d = '0;
            blank_d = 1'b1;
          end else if (expire) begin
            tick_d = 1'b1;
            if (others_req || !owner_req) begin
              state_d = StIdle;
              grant_d = '0;
              blank_d = 1'b1;
            end else begin
              cnt_d   = '0;
              digit_d = bus.req_digit[{ptr_q, 2'b00} +: 4];
            end
          end else if (!owner_req) begin
            state_d = StIdle;
            grant_d = '0;
            blank_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      grant_q <= '0;
      digit_q <= 4'd0;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      digit_q <= digit_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.seg_digit  = digit_q;
  assign bus.seg_blank  = blank_q;
  assign bus.dwell_tick = tick_q;
endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 7-segment digit path (the 4-bit digit that feeds the seg7 decoder) among NUM_REQ requesters.
- Grants are round-robin. Each grant has a minimum dwell time, timed by the same prescaler-compare scheme as the seconds counter: 0 on the switches selects the default, otherwise {ui_in, 10'b0}.
- Sits between requester blocks and the seg7 instance in the tt_um top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DWELL_W, 24, dwell counter width.
- DEFAULT_DWELL, 24'd10_000_000, compare value used when dwell_sel == 0.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- ena  input  1  design enable; when low, state is frozen.
- req  input  NUM_REQ  per-requester display request, level.
- req_digit  input  4*NUM_REQ  digit of requester i is on bits [4i+3:4i].
- dwell_sel  input  8  0 selects DEFAULT_DWELL; otherwise compare = {dwell_sel, 10'b0}, zero-extended to DWELL_W.
- grant  output  NUM_REQ  one-hot current owner; all zero when nobody owns the display.
- seg_digit  output  4  digit latched from the owner.
- seg_blank  output  1  high when there is no owner; the seg7 path must blank.
- dwell_tick  output  1  one-cycle pulse when the dwell counter reaches compare.

Behaviour:
- States: IDLE, SHOW. All outputs are registered.
- Reset, on a clk edge with rst_n=0, regardless of ena:
  - state=IDLE, grant=0, seg_digit=0, seg_blank=1, dwell_tick=0;
  - dwell counter=0;
  - rr pointer=NUM_REQ-1, so req[0] wins first.
- ena=0: state, counter, pointer and outputs hold; dwell_tick is forced to 0.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching pointer+1, pointer+2, ... with wrap modulo NUM_REQ.
  - Next edge: SHOW, grant=onehot(winner), seg_digit=req_digit[winner], seg_blank=0, counter=0, pointer=winner.
  - Latency: req seen at edge k gives grant valid after edge k.
  - With no req, stay in IDLE.
- SHOW:
  - Counter increments each cycle. Expiry happens when counter == compare, so a dwell lasts compare+1 cycles.
  - compare is re-evaluated every cycle; a dwell_sel change takes effect immediately. If the counter is already above the new compare, it wraps at 2^DWELL_W.
  - Expiry edge: dwell_tick=1 for one cycle.
    - If any other requester has req set: go to IDLE with grant=0 and seg_blank=1 (a one-cycle blank gap). Re-arbitration happens from IDLE.
    - Else if the owner's req is still set: counter=0, seg_digit re-latched from the owner, remain in SHOW.
    - Else: go to IDLE.
  - Owner drops req before expiry: next edge goes to IDLE. The minimum dwell is waived for a voluntary release.
  - Other requesters' req changes never disturb the current dwell. Exception: preemption, see Optional Feature.
- seg_digit changes only on grant or re-latch. The requester's digit changes mid-dwell are not shown.
- Digit values 10..15 are passed through unchanged; the decoder handles them.
- Simultaneous expiry and owner req drop: the "other requester pending" rule takes priority; otherwise go to IDLE. Result is the same blank gap.
- grant is never more than one-hot and is never nonzero while seg_blank=1.

Optional Feature:
- Macro: SEG_ARB_PREEMPT_EN.
- Defined:
  - req[0] is high priority. In SHOW with owner != 0, req[0]=1 forces IDLE at the next edge, ignoring dwell, with dwell_tick=0.
  - In IDLE, req[0] wins regardless of the pointer.
  - req[0], once owner, follows the normal rules.
- Undefined: pure round-robin as described; req[0] has no special treatment.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'hF → grant=0, seg_blank=1, seg_digit=0. Release with req=4'b0010 → grant=4'b0010 after 1 edge, seg_digit=req_digit[7:4].
- Dwell: dwell_sel=1, only req[2] set → dwell_tick every 1025 cycles; grant stays 4'b0100 with no blank gap; seg_digit re-latched at each tick.
- Round-robin: dwell_sel=1, req=4'b1011 held → grant order 0001, 0010, 1000, 0001. Each owner holds 1025 cycles, followed by a 1-cycle blank.
- Release and reset mid-dwell:
  - Owner req[1] drops at dwell count 100 → grant=0 on the next edge, no tick.
  - rst_n=0 mid-SHOW → IDLE on the next edge; pointer reset so req[0] wins next.
- Default and ena: dwell_sel=0 with DEFAULT_DWELL overridden to 50 in the bench → tick every 51 cycles. ena low for 10 cycles mid-dwell → expiry delayed by exactly 10 cycles.
- With SEG_ARB_PREEMPT_EN: owner 3 at count 20, req[0] rises → grant=0 next edge, then 4'b0001. Without the macro → owner 3 keeps the display until expiry.
